// File: rtl/clk_switch_pkg.sv
// rtl/clk_switch_pkg.sv - shared state encodings, select codes and select normalisation for the clock switch controller
//
// Purpose: constants and helpers shared by clk_switch_ctrl and its arbiter.
// Ports:   none (package).

package clk_switch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SWITCH = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam logic [1:0] SEL_IN0 = 2'b00;
    localparam logic [1:0] SEL_IN1 = 2'b01;
    localparam logic [1:0] SEL_IN2 = 2'b10;

    // The mux treats 2'b11 as clk_in2; folding it here keeps cur_sel
    // comparisons exact so 11 vs 10 is recognised as a null switch.
    function automatic logic [1:0] nsel(input logic [1:0] sel);
        return (sel == 2'b11) ? SEL_IN2 : sel;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
//
// Purpose: pick the first asserted request at or after ptr, wrapping at N_REQ.
// Ports:
//   req  in   N_REQ  request vector
//   ptr  in   IDX_W  highest-priority index this cycle (must be < N_REQ)
//   gnt  out  N_REQ  one-hot winner, zero when no request
//   idx  out  IDX_W  binary index of the winner, zero when no request

module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - round-robin sequencer driving the glitch-free clock mux select
//
// Purpose: grants one clock-select request at a time, drives cgm_sel, holds it
//          for SETTLE_CYC cycles, then pulses the requester's ack.
// Ports:
//   clk           in   1        always-on control clock
//   rst_clk_n     in   1        asynchronous active-low reset
//   scan_dc_mode  in   1        1 blocks new grants
//   req           in   N_REQ    level requests, held until ack
//   req_sel       in   2*N_REQ  target select, [2i+1:2i] for requester i
//   ack           out  N_REQ    one-cycle completion pulse
//   cgm_sel       out  2        registered mux select
//   cur_sel       out  2        last completed selection
//   busy          out  1        switch or completion in progress

module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int         N_REQ      = 3,
    parameter int         SETTLE_CYC = 16,
    parameter int         CNT_W      = 5,
    parameter logic [1:0] RST_SEL    = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst_clk_n,
    input  logic                 scan_dc_mode,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_sel,
    output logic [N_REQ-1:0]     ack,
    output logic [1:0]           cgm_sel,
    output logic [1:0]           cur_sel,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gidx;

    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   win_idx;
    logic [1:0]         win_sel;
    logic [IDX_W-1:0]   ptr_next;
    logic [N_REQ-1:0]   gidx_oh;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    always_comb begin
        win_sel = SEL_IN0;
        gidx_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_sel = nsel(req_sel[2*i +: 2]);
            end
            gidx_oh[i] = (gidx == IDX_W'(i));
        end
        ptr_next = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + IDX_W'(1);
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            state   <= ST_IDLE;
            cgm_sel <= nsel(RST_SEL);
            cur_sel <= nsel(RST_SEL);
            ack     <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            gidx    <= '0;
        end else begin
            // ack is only ever set on the edge entering DONE, so it is
            // automatically a single-cycle pulse.
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (!scan_dc_mode && (|req)) begin
                        gidx   <= win_idx;
                        rr_ptr <= ptr_next;
                        if (win_sel != cur_sel) begin
                            cgm_sel <= win_sel;
                            cnt     <= CNT_W'(SETTLE_CYC-1);
                            state   <= ST_SWITCH;
                        end else begin
                            // Already on the requested source: skip settling.
                            ack   <= gnt;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SWITCH: begin
                    if (cnt == '0) begin
                        cur_sel <= cgm_sel;
                        ack     <= gidx_oh;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - directed self-checking bench for clk_switch_ctrl

module tb_clk_switch_ctrl;

    logic       clk;
    logic       rst_clk_n;
    logic       scan_dc_mode;
    logic [2:0] req;
    logic [5:0] req_sel;
    logic [2:0] ack;
    logic [1:0] cgm_sel;
    logic [1:0] cur_sel;
    logic       busy;

    int n_pass;
    int n_total;

    clk_switch_ctrl #(
        .N_REQ      (3),
        .SETTLE_CYC (16),
        .CNT_W      (5),
        .RST_SEL    (2'b00)
    ) dut (
        .clk          (clk),
        .rst_clk_n    (rst_clk_n),
        .scan_dc_mode (scan_dc_mode),
        .req          (req),
        .req_sel      (req_sel),
        .ack          (ack),
        .cgm_sel      (cgm_sel),
        .cur_sel      (cur_sel),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Counts negedges until ack rises (bounded), then checks ack and latency.
    task automatic wait_ack(input string tag, input logic [2:0] exp_ack, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 3'b000 && n < 100);
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int bad;
        n_pass       = 0;
        n_total      = 0;
        rst_clk_n    = 1'b0;
        scan_dc_mode = 1'b0;
        req          = 3'b000;
        req_sel      = 6'b000000;
        repeat (2) @(negedge clk);
        check("rst_cgm_sel", 32'(cgm_sel), 32'h0);
        check("rst_cur_sel", 32'(cur_sel), 32'h0);
        check("rst_ack",     32'(ack),     32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        rst_clk_n = 1'b1;
        @(negedge clk);

        // 1: real switch to clk_in1 from requester 0
        req     = 3'b001;
        req_sel = 6'b000001;
        @(negedge clk);
        check("t1_cgm_sel", 32'(cgm_sel), 32'h1);
        check("t1_busy",    32'(busy),    32'h1);
        check("t1_cur_old", 32'(cur_sel), 32'h0);
        repeat (15) @(negedge clk);
        check("t1_no_ack_early", 32'(ack),  32'h0);
        check("t1_busy_late",    32'(busy), 32'h1);
        @(negedge clk);
        check("t1_ack", 32'(ack),     32'h1);
        check("t1_cur", 32'(cur_sel), 32'h1);
        req = 3'b000;
        @(negedge clk);
        check("t1_ack_clr",  32'(ack),  32'h0);
        check("t1_idle",     32'(busy), 32'h0);

        // 2: null switch from requester 1 (rr_ptr now 1)
        req     = 3'b010;
        req_sel = 6'b000100;
        @(negedge clk);
        check("t2_ack",  32'(ack),     32'h2);
        check("t2_busy", 32'(busy),    32'h1);
        check("t2_cgm",  32'(cgm_sel), 32'h1);
        req = 3'b000;
        @(negedge clk);
        check("t2_idle", 32'(busy),    32'h0);
        check("t2_cgm2", 32'(cgm_sel), 32'h1);

        // 3: simultaneous requests after reset, rr order 0,1,2
        rst_clk_n = 1'b0;
        @(negedge clk);
        rst_clk_n = 1'b1;
        req_sel   = 6'b010010;
        req       = 3'b111;
        wait_ack("t3_g0", 3'b001, 17);
        check("t3_cgm0", 32'(cgm_sel), 32'h2);
        req[0] = 1'b0;
        @(negedge clk);
        check("t3_gap0", 32'(busy), 32'h0);
        wait_ack("t3_g1", 3'b010, 17);
        check("t3_cgm1", 32'(cgm_sel), 32'h0);
        req[1] = 1'b0;
        @(negedge clk);
        check("t3_gap1", 32'(busy), 32'h0);
        wait_ack("t3_g2", 3'b100, 17);
        check("t3_cgm2", 32'(cgm_sel), 32'h1);
        check("t3_cur2", 32'(cur_sel), 32'h1);
        req = 3'b000;
        @(negedge clk);

        // 4: sel 11 normalises to 10; req dropped mid-switch still acks
        req_sel = 6'b000011;
        req     = 3'b001;
        repeat (4) @(negedge clk);
        check("t4_cgm_mid", 32'(cgm_sel), 32'h2);
        check("t4_busy",    32'(busy),    32'h1);
        req = 3'b000;
        wait_ack("t4", 3'b001, 13);
        check("t4_cgm", 32'(cgm_sel), 32'h2);
        check("t4_cur", 32'(cur_sel), 32'h2);
        @(negedge clk);
        check("t4_ack_pulse", 32'(ack), 32'h0);

        // 5: reset while cnt==5 in SWITCH
        req_sel = 6'b000100;
        req     = 3'b010;
        repeat (11) @(negedge clk);
        check("t5_cgm_pre", 32'(cgm_sel), 32'h1);
        rst_clk_n = 1'b0;
        #1;
        check("t5_cgm_rst",  32'(cgm_sel), 32'h0);
        check("t5_cur_rst",  32'(cur_sel), 32'h0);
        check("t5_busy_rst", 32'(busy),    32'h0);
        check("t5_ack_rst",  32'(ack),     32'h0);
        req = 3'b000;
        @(negedge clk);
        rst_clk_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack != 3'b000 || busy) bad++;
        end
        check("t5_no_ack_after", 32'(bad), 32'h0);

        // 6: scan blocks grants, then normal switch once released
        scan_dc_mode = 1'b1;
        req_sel      = 6'b010000;
        req          = 3'b100;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy || cgm_sel != 2'b00) bad++;
        end
        check("t6_scan_hold", 32'(bad), 32'h0);
        scan_dc_mode = 1'b0;
        wait_ack("t6", 3'b100, 17);
        check("t6_cur", 32'(cur_sel), 32'h1);
        req = 3'b000;
        @(negedge clk);
        check("t6_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
